// File: rtl/clcd_bus_driver_if.sv
// rtl/clcd_bus_driver_if.sv - Initiator and LCD bus signal bundle for clcd_bus_driver.
interface clcd_bus_driver_if;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;
  logic       oBusy;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (
    output iDATA, iRS, iStart,
    input  oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS
  );

  modport slave (
    input  iDATA, iRS, iStart,
    output oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS
  );
endinterface

// File: rtl/clcd_bus_driver.sv
// rtl/clcd_bus_driver.sv - Character LCD write-cycle sequencer (setup/EN pulse/hold/exec wait).
// Define CLCD_LONG_CMD_EN to give clear/home instructions the T_LONG execution wait.
module clcd_bus_driver #(
  parameter int T_SETUP = 4,
  parameter int T_EN    = 16,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2000,
  parameter int T_LONG  = 82000
) (
  input  logic iCLK,
  input  logic iRST_N,
  clcd_bus_driver_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_EXEC)), T_LONG);
  localparam int CW    = ($clog2(T_MAX + 1) > 17) ? $clog2(T_MAX + 1) : 17;

  localparam logic [CW-1:0] LEN_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] LEN_EN    = CW'(T_EN);
  localparam logic [CW-1:0] LEN_HOLD  = CW'(T_HOLD);
  localparam logic [CW-1:0] LEN_EXEC  = CW'(T_EXEC);
  localparam logic [CW-1:0] LEN_LONG  = CW'(T_LONG);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

  state_t        state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d, wait_len;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          start_q, start_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          start_rise, advance;
  logic [3:0]    phase_nz;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rs_d       = rs_q;
    start_d    = bus.iStart;
    advance    = 1'b0;
    nxt        = DONE;
    start_rise = bus.iStart & ~start_q;

    if (state_q == IDLE && start_rise) begin
      data_d = bus.iDATA;
      rs_d   = bus.iRS;
    end

    // data_d/rs_d so a transfer with all earlier phases zero sees the new byte
`ifdef CLCD_LONG_CMD_EN
    wait_len = (!rs_d && (data_d == 8'h01 || data_d == 8'h02 || data_d == 8'h03)) ? LEN_LONG : LEN_EXEC;
`else
    wait_len = LEN_EXEC;
`endif

    phase_nz = {wait_len != '0, LEN_HOLD != '0, LEN_EN != '0, LEN_SETUP != '0};

    case (state_q)
      IDLE:                     advance = start_rise;
      SETUP, PULSE, HOLD, EXEC: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default:                  state_d = IDLE;
    endcase

    // Earliest later phase with a nonzero length; zero-length phases are skipped outright
    if (phase_nz[3] && state_q < EXEC)  nxt = EXEC;
    if (phase_nz[2] && state_q < HOLD)  nxt = HOLD;
    if (phase_nz[1] && state_q < PULSE) nxt = PULSE;
    if (phase_nz[0] && state_q < SETUP) nxt = SETUP;

    if (advance) begin
      state_d = nxt;
      case (nxt)
        SETUP:   cnt_d = LEN_SETUP - 1'b1;
        PULSE:   cnt_d = LEN_EN - 1'b1;
        HOLD:    cnt_d = LEN_HOLD - 1'b1;
        EXEC:    cnt_d = wait_len - 1'b1;
        default: cnt_d = '0;
      endcase
    end

    en_d   = (state_d == PULSE);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      start_q <= start_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oDone    = done_q;
  assign bus.oBusy    = busy_q;
  assign bus.LCD_DATA = data_q;
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_EN   = en_q;
  assign bus.LCD_RW   = 1'b0;

endmodule

// File: tb/tb_clcd_bus_driver.sv
// tb/tb_clcd_bus_driver.sv - Testbench for clcd_bus_driver: default-timing vectors plus a short-timing randomized instance.
module tb_clcd_bus_driver;

  localparam int STD_LAT = 4 + 16 + 4 + 2000;
`ifdef CLCD_LONG_CMD_EN
  localparam int LONG_LAT = 4 + 16 + 4 + 82000;
  localparam bit LONG_ON  = 1'b1;
`else
  localparam int LONG_LAT = STD_LAT;
  localparam bit LONG_ON  = 1'b0;
`endif

  // Short-timing instance: T_SETUP=0, T_EN=16, T_HOLD=0, T_EXEC=1, T_LONG=5
  localparam int B_EN   = 16;
  localparam int B_EXEC = 1;
  localparam int B_LONG = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   nchecks = 0;
  int   nerr    = 0;
  bit   chk_on  = 1'b0;

  always #5 clk = ~clk;

  clcd_bus_driver_if a_if();
  clcd_bus_driver_if b_if();

  clcd_bus_driver dut_a (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (a_if)
  );

  clcd_bus_driver #(
    .T_SETUP (0),
    .T_EN    (B_EN),
    .T_HOLD  (0),
    .T_EXEC  (B_EXEC),
    .T_LONG  (B_LONG)
  ) dut_b (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (b_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference for instance B: a transfer accepted at edge acc shows EN on edges
  // [acc, acc+16), oDone on edge acc+total, busy through that edge.
  int         ncyc = 0;
  int         acc  = 0;
  bit         active = 1'b0;
  logic       prev_s = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_rs   = 1'b0;
  int         m_tot  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
      prev_s = 1'b0;
      m_data = 8'h00;
      m_rs   = 1'b0;
    end else begin
      ncyc++;
      if ((!active || (ncyc - 1 - acc) > m_tot) && b_if.iStart && !prev_s) begin
        acc    = ncyc;
        active = 1'b1;
        m_data = b_if.iDATA;
        m_rs   = b_if.iRS;
        if (LONG_ON && !m_rs && m_data >= 8'd1 && m_data <= 8'd3) m_tot = B_EN + B_LONG;
        else                                                    m_tot = B_EN + B_EXEC;
      end
      prev_s = b_if.iStart;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int k;
      k = ncyc - acc;
      chk("b_en",   32'(b_if.LCD_EN),   32'(active && k < B_EN));
      chk("b_done", 32'(b_if.oDone),    32'(active && k == m_tot));
      chk("b_busy", 32'(b_if.oBusy),    32'(active && k <= m_tot));
      chk("b_data", 32'(b_if.LCD_DATA), 32'(m_data));
      chk("b_rs",   32'(b_if.LCD_RS),   32'(m_rs));
      chk("b_rw",   32'(b_if.LCD_RW),   32'd0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       rs;
    bit         hold_high;
    int         retrig_at;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input bit prestarted);
    int  en_rise, en_len, done_cnt, done_at;
    bit  data_ok;
    if (!prestarted) begin
      @(negedge clk);
      a_if.iDATA  = v.data;
      a_if.iRS    = v.rs;
      a_if.iStart = 1'b1;
    end
    @(posedge clk);
    en_rise = -1; en_len = 0; done_cnt = 0; done_at = -1; data_ok = 1'b1;
    for (int cyc = 0; cyc < v.exp_lat + 40; cyc++) begin
      @(negedge clk);
      if (a_if.LCD_EN === 1'b1) begin
        if (en_rise < 0) en_rise = cyc;
        en_len++;
      end
      if (a_if.oDone === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      if (a_if.LCD_DATA !== v.data || a_if.LCD_RS !== v.rs) data_ok = 1'b0;
      if (v.retrig_at > 0 && cyc == v.retrig_at - 1) a_if.iStart = 1'b0;
      if (v.retrig_at > 0 && cyc == v.retrig_at) begin
        a_if.iStart = 1'b1;
        a_if.iDATA  = ~v.data;
        a_if.iRS    = ~v.rs;
      end
      if (!v.hold_high && v.retrig_at == 0 && cyc == 30) a_if.iStart = 1'b0;
    end
    a_if.iStart = 1'b0;
    chk("a_en_rise",  en_rise,  4);
    chk("a_en_len",   en_len,   16);
    chk("a_done_at",  done_at,  v.exp_lat);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_data_rs",  32'(data_ok), 32'd1);
  endtask

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h03;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    vecs[0] = '{data: 8'h38, rs: 1'b0, hold_high: 1'b0, retrig_at: 0,  exp_lat: STD_LAT};
    vecs[1] = '{data: 8'h55, rs: 1'b1, hold_high: 1'b1, retrig_at: 0,  exp_lat: STD_LAT};
    vecs[2] = '{data: 8'hA5, rs: 1'b1, hold_high: 1'b1, retrig_at: 10, exp_lat: STD_LAT};
    vecs[3] = '{data: 8'h01, rs: 1'b1, hold_high: 1'b0, retrig_at: 0,  exp_lat: STD_LAT};
    vecs[4] = '{data: 8'h01, rs: 1'b0, hold_high: 1'b0, retrig_at: 0,  exp_lat: LONG_LAT};

    rst_n = 1'b0;
    a_if.iDATA = 8'h00; a_if.iRS = 1'b0; a_if.iStart = 1'b0;
    b_if.iDATA = 8'h00; b_if.iRS = 1'b0; b_if.iStart = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en",   32'(a_if.LCD_EN),   32'd0);
    chk("rst_data", 32'(a_if.LCD_DATA), 32'd0);
    chk("rst_rs",   32'(a_if.LCD_RS),   32'd0);
    chk("rst_rw",   32'(a_if.LCD_RW),   32'd0);
    chk("rst_done", 32'(a_if.oDone),    32'd0);
    chk("rst_busy", 32'(a_if.oBusy),    32'd0);
    chk_on = 1'b1;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Reset while EN is high, then restart from iStart already high
    @(negedge clk);
    a_if.iDATA = 8'h3C; a_if.iRS = 1'b1; a_if.iStart = 1'b1;
    for (int i = 0; i < 50 && a_if.LCD_EN !== 1'b1; i++) @(negedge clk);
    chk("pre_rst_en", 32'(a_if.LCD_EN), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en",   32'(a_if.LCD_EN),   32'd0);
    chk("abort_data", 32'(a_if.LCD_DATA), 32'd0);
    chk("abort_rs",   32'(a_if.LCD_RS),   32'd0);
    chk("abort_done", 32'(a_if.oDone),    32'd0);
    chk("abort_busy", 32'(a_if.oBusy),    32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_vec('{data: 8'h3C, rs: 1'b1, hold_high: 1'b0, retrig_at: 0, exp_lat: STD_LAT}, 1'b1);

    // Randomized traffic on the short-timing instance, one reset in the middle
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      b_if.iDATA  = pick_data();
      b_if.iRS    = 1'($urandom_range(0, 1));
      b_if.iStart = 1'($urandom_range(0, 1));
      if (i == 30) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    b_if.iStart = 1'b0;
    repeat (30) @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
